// File: rtl/enigma_pkg.sv
// enigma_pkg: shared widths, port select and beat record for the enigma merge.
package enigma_pkg;
    localparam int PAYLOAD_W = 128;
    localparam int ID_W      = 5;
    localparam int TID_W     = ID_W + 1;

    typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_e;

    typedef struct packed {
        logic [PAYLOAD_W-1:0] payload;
        logic [ID_W-1:0]      id;
        logic [1:0]           qos;
    } beat_t;
endpackage

// File: rtl/enigma_port_fifo.sv
// enigma_port_fifo: DEPTH-entry beat FIFO; ready_o is a registered not-full flag.
module enigma_port_fifo
    import enigma_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push_i,
    input  beat_t beat_i,
    input  logic  pop_i,
    output beat_t head_o,
    output logic  empty_o,
    output logic  ready_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    beat_t         mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ready_q;

    assign cnt_d   = cnt_q + CW'(push_i) - CW'(pop_i);
    assign head_o  = mem_q[rd_q];
    assign empty_o = cnt_q == '0;
    assign ready_o = ready_q;

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= beat_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            wr_q    <= push_i ? wr_q + 1'b1 : wr_q;
            rd_q    <= pop_i ? rd_q + 1'b1 : rd_q;
            cnt_q   <= cnt_d;
            ready_q <= cnt_d != CW'(DEPTH);
        end
    end
endmodule

// File: rtl/enigma_merge.sv
// enigma_merge: merges ports A/B onto C by qos with round-robin tie-break and id tracking.
// Define ENIGMA_QOS_AGING_EN to force a starved port to qos 3 after AGE_LIMIT lost cycles.
module enigma_merge
    import enigma_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
`ifdef ENIGMA_QOS_AGING_EN
    , parameter int AGE_LIMIT = 15
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PAYLOAD_W-1:0] payload_a,
    input  logic [ID_W-1:0]      id_a,
    input  logic [1:0]           qos_a,
    input  logic                 valid_a,
    output logic                 ready_a,
    input  logic [PAYLOAD_W-1:0] payload_b,
    input  logic [ID_W-1:0]      id_b,
    input  logic [1:0]           qos_b,
    input  logic                 valid_b,
    output logic                 ready_b,
    output logic [PAYLOAD_W-1:0] payload_c,
    output logic [TID_W-1:0]     id_c,
    output logic [1:0]           qos_c,
    output logic                 valid_c,
    input  logic                 ready_c,
    input  logic                 conflict_c,
    input  logic                 release_c,
    input  logic [TID_W-1:0]     releaseid_c
);
    localparam int NID = 1 << TID_W;

    beat_t            head_a, head_b, slot_q, slot_d;
    logic             empty_a, empty_b, push_a, push_b, pop_a, pop_b;
    logic             elig_a, elig_b, load, done, valid_q, valid_d;
    logic [1:0]       qos_eff_a, qos_eff_b;
    logic [TID_W-1:0] tag_a, tag_b, tag_c;
    logic [NID-1:0]   out_q, out_d;
    port_e            grant, rr_q, rr_d, src_q, src_d;

    assign push_a = valid_a && ready_a;
    assign push_b = valid_b && ready_b;
    assign pop_a  = load && grant == PORT_A;
    assign pop_b  = load && grant == PORT_B;

    enigma_port_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_a (
        .clk(clk), .rst_n(rst_n), .push_i(push_a),
        .beat_i('{payload: payload_a, id: id_a, qos: qos_a}),
        .pop_i(pop_a), .head_o(head_a), .empty_o(empty_a), .ready_o(ready_a)
    );

    enigma_port_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_b (
        .clk(clk), .rst_n(rst_n), .push_i(push_b),
        .beat_i('{payload: payload_b, id: id_b, qos: qos_b}),
        .pop_i(pop_b), .head_o(head_b), .empty_o(empty_b), .ready_o(ready_b)
    );

    assign tag_a = {1'b0, head_a.id};
    assign tag_b = {1'b1, head_b.id};
    assign tag_c = {src_q, slot_q.id};

    // The beat sitting in the slot is about to become outstanding, so it blocks its id too.
    assign elig_a = !empty_a && !out_q[tag_a] && !(valid_q && tag_c == tag_a);
    assign elig_b = !empty_b && !out_q[tag_b] && !(valid_q && tag_c == tag_b);

`ifdef ENIGMA_QOS_AGING_EN
    logic [3:0] age_a_q, age_b_q;
    logic       lose_a, lose_b;

    assign lose_a    = load && elig_a && grant == PORT_B;
    assign lose_b    = load && elig_b && grant == PORT_A;
    assign qos_eff_a = age_a_q == 4'(AGE_LIMIT) ? 2'd3 : head_a.qos;
    assign qos_eff_b = age_b_q == 4'(AGE_LIMIT) ? 2'd3 : head_b.qos;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age_a_q <= '0;
            age_b_q <= '0;
        end else begin
            age_a_q <= pop_a ? '0 : (lose_a && age_a_q != 4'(AGE_LIMIT)) ? age_a_q + 4'd1 : age_a_q;
            age_b_q <= pop_b ? '0 : (lose_b && age_b_q != 4'(AGE_LIMIT)) ? age_b_q + 4'd1 : age_b_q;
        end
    end
`else
    assign qos_eff_a = head_a.qos;
    assign qos_eff_b = head_b.qos;
`endif

    assign grant = !elig_b ? PORT_A : !elig_a ? PORT_B :
                   qos_eff_a > qos_eff_b ? PORT_A : qos_eff_b > qos_eff_a ? PORT_B : rr_q;

    assign done    = valid_q && ready_c && !conflict_c;
    assign load    = (elig_a || elig_b) && (!valid_q || done);
    assign valid_d = load || (valid_q && !done);
    assign slot_d  = load ? (grant == PORT_A ? head_a : head_b) : slot_q;
    assign src_d   = load ? grant : src_q;
    assign rr_d    = load ? (grant == PORT_A ? PORT_B : PORT_A) :
                     (valid_q && ready_c && conflict_c) ? (src_q == PORT_A ? PORT_B : PORT_A) : rr_q;

    // Set is applied after clear so a same-cycle retire of the same id keeps the new beat outstanding.
    always_comb begin
        out_d = out_q;
        if (release_c) out_d[releaseid_c] = 1'b0;
        if (done) out_d[tag_c] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            slot_q  <= '0;
            src_q   <= PORT_A;
            rr_q    <= PORT_A;
            out_q   <= '0;
        end else begin
            valid_q <= valid_d;
            slot_q  <= slot_d;
            src_q   <= src_d;
            rr_q    <= rr_d;
            out_q   <= out_d;
        end
    end

    assign valid_c   = valid_q;
    assign payload_c = slot_q.payload;
    assign id_c      = tag_c;
    assign qos_c     = slot_q.qos;
endmodule

// File: tb/tb_enigma_merge.sv
// tb_enigma_merge: vector table plus scoreboard-checked sequences for enigma_merge.
module tb_enigma_merge;
    import enigma_pkg::*;

    logic                 clk = 1'b0, rst_n = 1'b1;
    logic [PAYLOAD_W-1:0] payload_a = '0, payload_b = '0, payload_c;
    logic [ID_W-1:0]      id_a = '0, id_b = '0;
    logic [1:0]           qos_a = '0, qos_b = '0, qos_c;
    logic                 valid_a = 1'b0, valid_b = 1'b0, ready_a, ready_b, valid_c;
    logic [TID_W-1:0]     id_c, releaseid_c = '0;
    logic                 ready_c = 1'b1, conflict_c = 1'b0, release_c = 1'b0;
    int                   checks = 0, passes = 0;

    typedef struct {
        logic [TID_W-1:0]     tid;
        logic [1:0]           qos;
        logic [PAYLOAD_W-1:0] pl;
    } exp_t;

    typedef struct {
        logic                 p;
        logic [ID_W-1:0]      id;
        logic [1:0]           qos;
        logic [PAYLOAD_W-1:0] pl;
        logic [TID_W-1:0]     exp_tid;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vt[6];

    always #5 clk = ~clk;

    enigma_merge dut (
        .clk(clk), .rst_n(rst_n),
        .payload_a(payload_a), .id_a(id_a), .qos_a(qos_a), .valid_a(valid_a), .ready_a(ready_a),
        .payload_b(payload_b), .id_b(id_b), .qos_b(qos_b), .valid_b(valid_b), .ready_b(ready_b),
        .payload_c(payload_c), .id_c(id_c), .qos_c(qos_c), .valid_c(valid_c), .ready_c(ready_c),
        .conflict_c(conflict_c), .release_c(release_c), .releaseid_c(releaseid_c)
    );

    task automatic chk(input string name, input logic [PAYLOAD_W-1:0] act, input logic [PAYLOAD_W-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n && valid_c && ready_c && !conflict_c) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected beat: got id_c %0h, expected no beat", id_c);
            end else begin
                mon_e = sb.pop_front();
                chk("id_c", id_c, mon_e.tid);
                chk("qos_c", qos_c, mon_e.qos);
                chk("payload_c", payload_c, mon_e.pl);
            end
        end
    end

    task automatic send(input logic p, input logic [ID_W-1:0] id, input logic [1:0] qos,
                        input logic [PAYLOAD_W-1:0] pl, input logic [TID_W-1:0] tid);
        chk("ready before push", p ? ready_b : ready_a, 1);
        if (p) begin
            valid_b = 1'b1; id_b = id; qos_b = qos; payload_b = pl;
        end else begin
            valid_a = 1'b1; id_a = id; qos_a = qos; payload_a = pl;
        end
        sb.push_back('{tid, qos, pl});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        valid_a = 1'b0;
        valid_b = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain pending beats", sb.size(), 0);
    endtask

    task automatic rel(input logic [TID_W-1:0] tid);
        release_c   = 1'b1;
        releaseid_c = tid;
        @(posedge clk);
        #1;
        release_c = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("reset valid_c", valid_c, 0);
        chk("reset ready_a", ready_a, 0);
        chk("reset ready_b", ready_b, 0);
        chk("reset payload_c", payload_c, 0);
        chk("reset id_c", id_c, 0);
        chk("reset qos_c", qos_c, 0);
        chk("reset bitmap", dut.out_q, 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{1'b1, 5'd31, 2'd3, 128'h11111111_22222222_33333333_44444444, 6'h3F};
        vt[1] = '{1'b0, 5'd0,  2'd0, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 6'h00};
        vt[2] = '{1'b0, 5'd31, 2'd2, 128'h00000000_00000000_00000000_00000001, 6'h1F};
        vt[3] = '{1'b1, 5'd0,  2'd1, 128'h80000000_00000000_00000000_00000000, 6'h20};
        vt[4] = '{1'b0, 5'd17, 2'd3, 128'hA5A5A5A5_5A5A5A5A_A5A5A5A5_5A5A5A5A, 6'h11};
        vt[5] = '{1'b1, 5'd9,  2'd2, 128'h01234567_89ABCDEF_FEDCBA98_76543210, 6'h29};

        #1;
        do_reset();
        chk("ready_a after reset", ready_a, 1);

        send(1'b0, 5'd3, 2'd1, 128'hC0FFEE00_00000000_00000000_0000DEAD, 6'h03);
        tick();
        chk("latency cycle1 valid_c", valid_c, 0);
        @(posedge clk);
        #1;
        chk("latency cycle2 valid_c", valid_c, 1);
        @(posedge clk);
        #1;
        chk("outstanding[3] set", dut.out_q[3], 1);
        rel(6'h03);
        chk("outstanding[3] cleared", dut.out_q[3], 0);

        foreach (vt[i]) begin
            send(vt[i].p, vt[i].id, vt[i].qos, vt[i].pl, vt[i].exp_tid);
            tick();
            drain(10);
            rel(vt[i].exp_tid);
        end

        // Equal qos from both ports: round-robin starts at A after reset.
        do_reset();
        send(1'b0, 5'd1, 2'd2, 128'hA1, 6'h01);
        send(1'b1, 5'd2, 2'd2, 128'hB2, 6'h22);
        tick();
        send(1'b0, 5'd3, 2'd2, 128'hA3, 6'h03);
        send(1'b1, 5'd4, 2'd2, 128'hB4, 6'h24);
        tick();
        drain(20);
        rel(6'h01); rel(6'h22); rel(6'h03); rel(6'h24);

        // Higher qos on B beats a round-robin pointer sitting at A.
        send(1'b1, 5'd7, 2'd3, 128'hB7, 6'h27);
        send(1'b0, 5'd6, 2'd0, 128'hA6, 6'h06);
        tick();
        drain(20);
        rel(6'h27); rel(6'h06);

        // Same id without release stays blocked in the FIFO.
        send(1'b0, 5'd5, 2'd1, 128'h5151, 6'h05);
        tick();
        send(1'b0, 5'd5, 2'd1, 128'h5252, 6'h05);
        tick();
        repeat (6) @(posedge clk);
        #1;
        chk("same-id second beat held", sb.size(), 1);
        chk("same-id valid_c low", valid_c, 0);
        rel(6'h05);
        @(posedge clk);
        #1;
        chk("after release valid_c", valid_c, 1);
        drain(10);
        rel(6'h05);

        // Conflict holds the beat; then B wins the next grant.
        conflict_c = 1'b1;
        send(1'b0, 5'd7, 2'd1, 128'hC0C0_7777, 6'h07);
        tick();
        send(1'b1, 5'd10, 2'd1, 128'hB10, 6'h2A);
        send(1'b0, 5'd9, 2'd1, 128'hA9, 6'h09);
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("conflict valid_c held", valid_c, 1);
            chk("conflict id_c held", id_c, 6'h07);
            chk("conflict payload held", payload_c, 128'hC0C0_7777);
            @(posedge clk);
            #1;
        end
        conflict_c = 1'b0;
        drain(20);
        rel(6'h07); rel(6'h2A); rel(6'h09);

        // Leave id 20 outstanding, fill port A with the consumer stalled, then reset.
        send(1'b0, 5'd20, 2'd1, 128'h2020, 6'h14);
        tick();
        drain(10);
        chk("outstanding[20] set", dut.out_q[20], 1);
        ready_c = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("fill ready_a", ready_a, 1);
            valid_a = 1'b1; id_a = 5'(21 + k); qos_a = 2'd1; payload_a = 128'(k + 100);
            tick();
        end
        chk("full ready_a", ready_a, 0);
        chk("stalled valid_c", valid_c, 1);
        do_reset();
        ready_c = 1'b1;
        send(1'b0, 5'd20, 2'd1, 128'hF00D, 6'h14);
        tick();
        drain(10);
        send(1'b1, 5'd20, 2'd2, 128'hBEEF, 6'h34);
        tick();
        drain(10);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
